// File: rtl/cntr8_ctrl.sv
// ---------------------------------------------------------------------------
// cntr8_ctrl
//
// Control half of an up/down counter. The block holds a state and an 8-bit
// data register. The arithmetic is done outside this block: the external
// output-logic stage reads state and d_reg and returns its result on fb_in.
// This block only chooses the next state and whether d_reg takes d_in,
// fb_in, or keeps its value.
//
// Ports
//   clk    : rising-edge clock for all registers
//   reset  : synchronous active-high reset, sampled on the rising edge of clk
//   en     : advance enable; when 0, all registers hold
//   load   : load request; highest priority after reset
//   inc    : counting direction, 1 = up, 0 = down
//   d_in   : external load value
//   fb_in  : result from the output-logic stage for the current state/d_reg
//   state  : registered current state
//   d_reg  : registered data value
// ---------------------------------------------------------------------------
module cntr8_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic       inc,
    input  logic [7:0] d_in,
    input  logic [7:0] fb_in,
    output logic [2:0] state,
    output logic [7:0] d_reg
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        INC2 = 3'b011,
        DEC  = 3'b100,
        DEC2 = 3'b101
    } state_t;

    // The state register is a plain vector, not a state_t. This way the
    // unused codes 110 and 111 can be stored in it, and the recovery path
    // can be reached.
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [7:0] dreg_q;
    logic [7:0] dreg_d;

    // Next-state and next-data logic.
    // The checks run in this order:
    //   1. Unused codes go back to IDLE and clear the data. Load is ignored.
    //   2. A load request moves to LOAD and captures d_in.
    //   3. Otherwise the transition table applies. The data takes the
    //      feedback value in every state except IDLE, which holds.
    always_comb begin
        state_d = state_q;
        dreg_d  = dreg_q;

        if (state_q[2] && state_q[1]) begin
            state_d = IDLE;
            dreg_d  = 8'h00;
        end else if (load) begin
            state_d = LOAD;
            dreg_d  = d_in;
        end else begin
            case (state_q)
                IDLE:    state_d = inc ? INC  : DEC;
                LOAD:    state_d = inc ? INC  : DEC;
                INC:     state_d = inc ? INC2 : DEC;
                INC2:    state_d = inc ? INC  : DEC;
                DEC:     state_d = inc ? INC  : DEC2;
                DEC2:    state_d = inc ? INC  : DEC;
                default: state_d = IDLE;
            endcase

            if (state_q != IDLE) begin
                dreg_d = fb_in;
            end
        end
    end

    // State and data registers.
    // Reset has priority over everything. With reset low, the registers
    // change only when en is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dreg_q  <= 8'h00;
        end else if (en) begin
            state_q <= state_d;
            dreg_q  <= dreg_d;
        end
    end

    // The outputs come straight from the registers, so there is no
    // combinational path from any input to any output.
    assign state = state_q;
    assign d_reg = dreg_q;

endmodule

// File: tb/tb_cntr8_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cntr8_ctrl
//
// Self-checking bench for cntr8_ctrl.
//
// A behavioural model in the bench tracks the expected state and d_reg:
//   - reset has top priority;
//   - en = 0 holds both values;
//   - an unused code returns to IDLE with cleared data;
//   - load has priority over counting;
//   - counting follows the direction rules.
//
// Fixed scenarios run first. A randomized run follows, with fb_in mostly
// modelled as d_reg +/- 1.
// ---------------------------------------------------------------------------
module tb_cntr8_ctrl;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_LOAD = 3'b001;
    localparam logic [2:0] S_INC  = 3'b010;
    localparam logic [2:0] S_INC2 = 3'b011;
    localparam logic [2:0] S_DEC  = 3'b100;
    localparam logic [2:0] S_DEC2 = 3'b101;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic       inc;
    logic [7:0] dIn;
    logic [7:0] fbIn;
    logic [2:0] state;
    logic [7:0] dReg;

    logic [2:0] modelState;
    logic [7:0] modelDreg;

    int checkCount;
    int errorCount;

    cntr8_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .load  (load),
        .inc   (inc),
        .d_in  (dIn),
        .fb_in (fbIn),
        .state (state),
        .d_reg (dReg)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison, and report it when the observed value differs
    // from the expected value.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    // Direction rule: counting up alternates INC and INC2 while inc stays 1.
    // Counting down alternates DEC and DEC2 while inc stays 0. Any other
    // entry into counting starts at the first state of that direction.
    function automatic logic [2:0] countNext(input logic [2:0] cur, input logic up);
        if (up) begin
            return (cur == S_INC) ? S_INC2 : S_INC;
        end
        return (cur == S_DEC) ? S_DEC2 : S_DEC;
    endfunction

    // Drive one cycle of inputs at the falling edge. Predict the result,
    // let one rising edge pass, then compare on the next falling edge.
    task automatic applyStimulus(input logic r, input logic e, input logic l,
                                 input logic i, input logic [7:0] d,
                                 input logic [7:0] fb, input string tag);
        logic [2:0] expState;
        logic [7:0] expDreg;
        reset = r;
        en    = e;
        load  = l;
        inc   = i;
        dIn   = d;
        fbIn  = fb;
        expState = modelState;
        expDreg  = modelDreg;
        if (r) begin
            expState = S_IDLE;
            expDreg  = 8'h00;
        end else if (e) begin
            if (modelState > S_DEC2) begin
                expState = S_IDLE;
                expDreg  = 8'h00;
            end else if (l) begin
                expState = S_LOAD;
                expDreg  = d;
            end else begin
                expState = countNext(modelState, i);
                if (modelState != S_IDLE) expDreg = fb;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, ".state"}, {5'd0, state}, {5'd0, expState});
        checkOutput({tag, ".d_reg"}, dReg, expDreg);
        modelState = expState;
        modelDreg  = expDreg;
    endtask

    // Place an unused code directly in the state register, away from the
    // clock edge. The forced value stays in the register after release.
    task automatic forceBadState(input logic [2:0] code);
        force dut.state_q = code;
        #1;
        release dut.state_q;
        modelState = code;
    endtask

    initial begin
        logic [7:0] fbVal;
        checkCount = 0;
        errorCount = 0;
        modelState = S_IDLE;
        modelDreg  = 8'h00;
        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        inc   = 1'b0;
        dIn   = 8'h00;
        fbIn  = 8'h00;
        @(negedge clk);

        // Reset for two cycles.
        applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, "reset0");
        applyStimulus(1, 1, 1, 1, 8'h5A, 8'h77, "reset1");

        // en = 0: a load request must be ignored.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 1, 8'hAA, 8'h11, "holdEn0");
        end

        // Load FF, then count up. The FF+1 feedback wraps to 00.
        applyStimulus(0, 1, 1, 0, 8'hFF, 8'h00, "loadFF");
        for (int k = 0; k < 4; k++) begin
            fbVal = modelDreg + 8'd1;
            applyStimulus(0, 1, 0, 1, 8'h00, fbVal, "countUp");
        end

        // Load FF, then count down: expect FE, FD, FC.
        applyStimulus(0, 1, 1, 1, 8'hFF, 8'h00, "loadFF2");
        for (int k = 0; k < 3; k++) begin
            fbVal = modelDreg - 8'd1;
            applyStimulus(0, 1, 0, 0, 8'h00, fbVal, "countDown");
        end

        // Count down from 00: the feedback wraps to FF.
        applyStimulus(0, 1, 1, 0, 8'h00, 8'h00, "load00");
        applyStimulus(0, 1, 0, 0, 8'h00, 8'hFF, "wrapDown");

        // Reach INC2. A load on the same edge as a down request wins.
        applyStimulus(0, 1, 1, 1, 8'h10, 8'h00, "load10");
        applyStimulus(0, 1, 0, 1, 8'h00, 8'h11, "toInc");
        applyStimulus(0, 1, 0, 1, 8'h00, 8'h12, "toInc2");
        applyStimulus(0, 1, 1, 0, 8'h3C, 8'h99, "loadWins");

        // Unused codes recover to IDLE with cleared data. Load is ignored.
        applyStimulus(0, 1, 1, 0, 8'h55, 8'h00, "load55");
        forceBadState(3'b110);
        applyStimulus(0, 1, 0, 0, 8'h00, 8'h44, "bad110");
        applyStimulus(0, 1, 1, 0, 8'h66, 8'h00, "load66");
        forceBadState(3'b111);
        applyStimulus(0, 1, 1, 1, 8'h77, 8'h44, "bad111");

        // From IDLE, counting takes the IDLE row and d_reg holds.
        applyStimulus(0, 1, 0, 1, 8'h00, 8'h9D, "idleHold");

        // Reset during INC2 with d_reg = 80 aborts the sequence.
        // The next edge takes the IDLE row again.
        applyStimulus(0, 1, 1, 0, 8'h7E, 8'h00, "load7E");
        applyStimulus(0, 1, 0, 1, 8'h00, 8'h7F, "to7F");
        applyStimulus(0, 1, 0, 1, 8'h00, 8'h80, "to80");
        applyStimulus(1, 1, 1, 0, 8'hC3, 8'h81, "midReset");
        applyStimulus(0, 1, 0, 0, 8'h00, 8'h42, "afterReset");

        // Toggle inc on consecutive cycles.
        for (int k = 0; k < 6; k++) begin
            fbVal = (k % 2 == 0) ? modelDreg + 8'd1 : modelDreg - 8'd1;
            applyStimulus(0, 1, 0, (k % 2 == 0), 8'h00, fbVal, "toggle");
        end

        // Randomized run.
        for (int k = 0; k < 400; k++) begin
            logic rr, ee, ll, ii;
            logic [7:0] dd;
            rr = ($urandom_range(0, 24) == 0);
            ee = ($urandom_range(0, 3) != 0);
            ll = ($urandom_range(0, 7) == 0);
            ii = $urandom_range(0, 1);
            dd = $urandom_range(0, 255);
            if ($urandom_range(0, 5) == 0) begin
                fbVal = $urandom_range(0, 255);
            end else if (modelState == S_INC || modelState == S_INC2) begin
                fbVal = modelDreg + 8'd1;
            end else if (modelState == S_DEC || modelState == S_DEC2) begin
                fbVal = modelDreg - 8'd1;
            end else begin
                fbVal = $urandom_range(0, 255);
            end
            applyStimulus(rr, ee, ll, ii, dd, fbVal, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cntr8_ctrl.md
CNTR8_CTRL -- requirements
Module: cntr8_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all registers.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 en  input  1  advance enable; 0 holds all registers.
REQ-005 load  input  1  load request; highest priority after reset.
REQ-006 inc  input  1  direction: 1 = count up, 0 = count down.
REQ-007 d_in  input  8  external load value.
REQ-008 fb_in  input  8  feedback value, i.e. the output-logic result for the current state and d_reg.
REQ-009 state  output  3  registered current state, driven directly into the output-logic stage.
REQ-010 d_reg  output  8  registered data value, driven into the output-logic data input.

Function
REQ-011 State encoding SHALL be IDLE=000, LOAD=001, INC=010, INC2=011, DEC=100, DEC2=101.
REQ-012 state and d_reg SHALL change only on a rising clk edge, and only when reset=1 or en=1.
REQ-013 With en=1 and load=1, next state SHALL be LOAD from any state, including LOAD itself.
REQ-014 With en=1 and load=0, IDLE SHALL go to INC if inc=1, else to DEC.
REQ-015 With en=1 and load=0, LOAD SHALL go to INC if inc=1, else to DEC.
REQ-016 With en=1 and load=0, INC SHALL go to INC2 if inc=1, else to DEC.
REQ-017 With en=1 and load=0, INC2 SHALL go to INC if inc=1, else to DEC.
REQ-018 With en=1 and load=0, DEC SHALL go to DEC2 if inc=0, else to INC.
REQ-019 With en=1 and load=0, DEC2 SHALL go to DEC if inc=0, else to INC.
REQ-020 Unused encodings 110/111 SHALL go to IDLE on the next enabled edge, with d_reg cleared to 0; load is ignored in that cycle.
REQ-021 With en=1 and load=1, d_reg SHALL capture d_in on the same edge that state enters LOAD.
REQ-022 With en=1, load=0 and state not IDLE, d_reg SHALL capture fb_in.
REQ-023 With en=1, load=0 and state IDLE, d_reg SHALL hold its value.
REQ-024 d_reg SHALL be a plain 8-bit register with no arithmetic; wrap-around (FF+1 -> 00, 00-1 -> FF) is produced by the feedback source and SHALL pass through unchanged.
REQ-025 Latency SHALL be exactly one clock from a qualifying input to updated state and d_reg, with no combinational path from any input to any output.
REQ-026 When inc toggles on consecutive cycles, the block SHALL apply the transition table each cycle without extra IDLE cycles.

Reset
REQ-027 On an edge with reset=1, state SHALL become IDLE (000) and d_reg SHALL become 8'h00, regardless of en, load and inc.
REQ-028 Reset asserted mid-count SHALL abort the sequence; the first enabled edge after reset deasserts SHALL follow the IDLE row of the transition table.
REQ-029 Before the first reset edge, output values are undefined; the bench SHALL apply reset for at least 2 cycles before checking outputs.

Verification
REQ-030 Reset for 2 cycles, then en=0 with load=1 for 3 cycles -> state=000 and d_reg=00 throughout.
REQ-031 en=1, load=1, d_in=8'hFF for 1 cycle -> state=001 and d_reg=FF one edge later; then load=0, inc=1 -> states 010, 011, 010, ... with d_reg tracking fb_in.
REQ-032 From state LOAD with d_reg=FF, inc=0 and fb_in modelled as d_reg-1 for 3 edges -> states 100, 101, 100 and d_reg FE, FD, FC.
REQ-033 From INC2, with load=1 and inc=0 on the same edge, d_in=8'h3C -> state=001 and d_reg=3C (load wins).
REQ-034 Force state=110, en=1, load=0 for 1 edge -> state=000 and d_reg=00; then reset during INC2 with d_reg=8'h80 -> state=000 and d_reg=00 on the next edge.
